// File: rtl/fetch_issue_queue.sv
// fetch_issue_queue
// Circular instruction buffer between fetch (IF) and dual-issue decode (ID).
// Up to two fetched instructions are accepted per cycle and packed in order.
// The two oldest entries are presented combinationally to the decoder as
// lane 0 and lane 1.
//
// Ports:
//   clk, rst                     core clock, synchronous active-high reset
//   IF_Valid[1:0]                fetch slot valids ([0]=slot0, [1]=slot1)
//   IF_PC0/IF_Inst0              slot0 PC and instruction
//   IF_PC1/IF_Inst1              slot1 PC and instruction
//   Ctrl_StallID                 hold decode, no dequeue
//   Ctrl_FlushIFID               drop all queued and incoming instructions
//   Issue_Single                 decoder takes lane 0 only this cycle
//   Fetch_StallReq               back-pressure, fetch must hold its data
//   ID_Valid[1:0]                lane valids
//   ID_PC0/ID_Inst0              lane 0 (oldest entry)
//   ID_PC1/ID_Inst1              lane 1 (second-oldest entry)
//   Queue_Count                  current occupancy
//
// Optional feature macro FIQ_PERF_EN adds saturating counters
//   Perf_FullCycles (cycles with Fetch_StallReq=1) and
//   Perf_FlushCnt   (cycles with Ctrl_FlushIFID=1).
module fetch_issue_queue #(
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               IF_Valid,
  input  logic [ADDR_WIDTH-1:0]    IF_PC0,
  input  logic [INST_WIDTH-1:0]    IF_Inst0,
  input  logic [ADDR_WIDTH-1:0]    IF_PC1,
  input  logic [INST_WIDTH-1:0]    IF_Inst1,
  input  logic                     Ctrl_StallID,
  input  logic                     Ctrl_FlushIFID,
  input  logic                     Issue_Single,
  output logic                     Fetch_StallReq,
  output logic [1:0]               ID_Valid,
  output logic [ADDR_WIDTH-1:0]    ID_PC0,
  output logic [INST_WIDTH-1:0]    ID_Inst0,
  output logic [ADDR_WIDTH-1:0]    ID_PC1,
  output logic [INST_WIDTH-1:0]    ID_Inst1,
`ifdef FIQ_PERF_EN
  output logic [31:0]              Perf_FullCycles,
  output logic [31:0]              Perf_FlushCnt,
`endif
  output logic [$clog2(DEPTH):0]   Queue_Count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];
  logic [INST_WIDTH-1:0] inst_mem [DEPTH];

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr_nx1;
  logic [PW-1:0] wr_ptr_s1;
  logic [CW-1:0] count;

  logic       enq_en;
  logic       deq_en;
  logic [1:0] enq_n;
  logic [1:0] deq_n;

  // Head presentation: lane 1 index wraps naturally through pointer width.
  assign rd_ptr_nx1     = rd_ptr + PW'(1);
  assign ID_PC0         = pc_mem[rd_ptr];
  assign ID_Inst0       = inst_mem[rd_ptr];
  assign ID_PC1         = pc_mem[rd_ptr_nx1];
  assign ID_Inst1       = inst_mem[rd_ptr_nx1];
  assign ID_Valid       = {(count >= CW'(2)), (count != '0)};
  assign Queue_Count    = count;

  // Stall is judged on the current count only, so a pair can always land
  // without needing entries freed by this cycle's dequeue.
  assign Fetch_StallReq = (count >= CW'(DEPTH - 1));

  assign enq_en = !Ctrl_FlushIFID && !Fetch_StallReq;
  assign deq_en = !Ctrl_FlushIFID && !Ctrl_StallID;

  // Slot1 packs behind slot0 only when slot0 is actually present.
  assign wr_ptr_s1 = wr_ptr + PW'(IF_Valid[0]);

  always_comb begin
    enq_n = 2'd0;
    deq_n = 2'd0;
    if (enq_en)
      enq_n = {1'b0, IF_Valid[0]} + {1'b0, IF_Valid[1]};
    if (deq_en && (count != '0)) begin
      if (Issue_Single || (count == CW'(1)))
        deq_n = 2'd1;
      else
        deq_n = 2'd2;
    end
  end

  // Control state: pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (Ctrl_FlushIFID) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + PW'(deq_n);
      wr_ptr <= wr_ptr + PW'(enq_n);
      count  <= count + CW'(enq_n) - CW'(deq_n);
    end
  end

  // Storage: data only, never reset.
  always_ff @(posedge clk) begin
    if (!rst && enq_en && IF_Valid[0]) begin
      pc_mem[wr_ptr]   <= IF_PC0;
      inst_mem[wr_ptr] <= IF_Inst0;
    end
    if (!rst && enq_en && IF_Valid[1]) begin
      pc_mem[wr_ptr_s1]   <= IF_PC1;
      inst_mem[wr_ptr_s1] <= IF_Inst1;
    end
  end

`ifdef FIQ_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      Perf_FullCycles <= '0;
      Perf_FlushCnt   <= '0;
    end else begin
      if (Fetch_StallReq && (Perf_FullCycles != 32'hFFFF_FFFF))
        Perf_FullCycles <= Perf_FullCycles + 32'd1;
      if (Ctrl_FlushIFID && (Perf_FlushCnt != 32'hFFFF_FFFF))
        Perf_FlushCnt <= Perf_FlushCnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_issue_queue.sv
// Scoreboard bench for fetch_issue_queue (DEPTH=8). The stimulus process
// pushes the expected post-edge head state for every driven cycle; a
// monitor pops and compares shortly after each rising edge.
module tb_fetch_issue_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  IF_Valid;
  logic [31:0] IF_PC0, IF_Inst0, IF_PC1, IF_Inst1;
  logic        Ctrl_StallID, Ctrl_FlushIFID, Issue_Single;
  logic        Fetch_StallReq;
  logic [1:0]  ID_Valid;
  logic [31:0] ID_PC0, ID_Inst0, ID_PC1, ID_Inst1;
  logic [3:0]  Queue_Count;
`ifdef FIQ_PERF_EN
  logic [31:0] Perf_FullCycles, Perf_FlushCnt;
`endif

  fetch_issue_queue #(.DEPTH(8), .ADDR_WIDTH(32), .INST_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .IF_Valid(IF_Valid),
    .IF_PC0(IF_PC0), .IF_Inst0(IF_Inst0),
    .IF_PC1(IF_PC1), .IF_Inst1(IF_Inst1),
    .Ctrl_StallID(Ctrl_StallID), .Ctrl_FlushIFID(Ctrl_FlushIFID),
    .Issue_Single(Issue_Single),
    .Fetch_StallReq(Fetch_StallReq),
    .ID_Valid(ID_Valid),
    .ID_PC0(ID_PC0), .ID_Inst0(ID_Inst0),
    .ID_PC1(ID_PC1), .ID_Inst1(ID_Inst1),
`ifdef FIQ_PERF_EN
    .Perf_FullCycles(Perf_FullCycles), .Perf_FlushCnt(Perf_FlushCnt),
`endif
    .Queue_Count(Queue_Count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  v;
    logic [31:0] pc0;
    logic [31:0] pc1;
    logic [3:0]  cnt;
    logic        st;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   stim_done = 1'b0;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return ~pc ^ 32'h5A00_0000;
  endfunction

  task automatic chk(input string name, input string fld,
                     input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s actual=0x%0h required=0x%0h", name, fld, act, req);
    end
  endtask

  // One cycle: drive inputs at the falling edge, push expectation after
  // the rising edge that consumes them.
  task automatic cyc(input string name, input logic r, input logic [1:0] v,
                     input logic [31:0] p0, input logic [31:0] p1,
                     input logic st, input logic fl, input logic sg,
                     input logic [1:0] ev, input logic [31:0] ep0,
                     input logic [31:0] ep1, input logic [3:0] ec,
                     input logic es);
    exp_t e;
    @(negedge clk);
    rst = r; IF_Valid = v;
    IF_PC0 = p0; IF_Inst0 = inst_of(p0);
    IF_PC1 = p1; IF_Inst1 = inst_of(p1);
    Ctrl_StallID = st; Ctrl_FlushIFID = fl; Issue_Single = sg;
    @(posedge clk);
    e.name = name; e.v = ev; e.pc0 = ep0; e.pc1 = ep1; e.cnt = ec; e.st = es;
    exp_q.push_back(e);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk(e.name, "valid", {30'd0, ID_Valid}, {30'd0, e.v});
        chk(e.name, "count", {28'd0, Queue_Count}, {28'd0, e.cnt});
        chk(e.name, "stallreq", {31'd0, Fetch_StallReq}, {31'd0, e.st});
        if (e.v[0]) begin
          chk(e.name, "pc0", ID_PC0, e.pc0);
          chk(e.name, "inst0", ID_Inst0, inst_of(e.pc0));
        end
        if (e.v[1]) begin
          chk(e.name, "pc1", ID_PC1, e.pc1);
          chk(e.name, "inst1", ID_Inst1, inst_of(e.pc1));
        end
      end
    end
  end

  initial begin
    rst = 1'b1; IF_Valid = 2'b00;
    IF_PC0 = '0; IF_Inst0 = '0; IF_PC1 = '0; IF_Inst1 = '0;
    Ctrl_StallID = 1'b0; Ctrl_FlushIFID = 1'b0; Issue_Single = 1'b0;

    //   name         rst v      pc0       pc1      stl fl sg  ev     epc0      epc1     cnt st
    cyc("reset",      1, 2'b00, 32'h0,    32'h0,    0, 0, 0, 2'b00, 32'h0,    32'h0,    0, 0);
    cyc("first_pair", 0, 2'b11, 32'h100,  32'h104,  1, 0, 0, 2'b11, 32'h100,  32'h104,  2, 0);
    cyc("second_pair",0, 2'b11, 32'h108,  32'h10C,  1, 0, 0, 2'b11, 32'h100,  32'h104,  4, 0);
    cyc("single_iss", 0, 2'b00, 32'h0,    32'h0,    0, 0, 1, 2'b11, 32'h104,  32'h108,  3, 0);
    cyc("flush_a",    0, 2'b00, 32'h0,    32'h0,    0, 1, 0, 2'b00, 32'h0,    32'h0,    0, 0);
    // Fill under decode stall.
    cyc("fill_2",     0, 2'b11, 32'h400,  32'h404,  1, 0, 0, 2'b11, 32'h400,  32'h404,  2, 0);
    cyc("fill_4",     0, 2'b11, 32'h408,  32'h40C,  1, 0, 0, 2'b11, 32'h400,  32'h404,  4, 0);
    cyc("fill_6",     0, 2'b11, 32'h410,  32'h414,  1, 0, 0, 2'b11, 32'h400,  32'h404,  6, 0);
    cyc("fill_7",     0, 2'b01, 32'h418,  32'h0,    1, 0, 0, 2'b11, 32'h400,  32'h404,  7, 1);
    cyc("ignored_in", 0, 2'b11, 32'h500,  32'h504,  1, 0, 0, 2'b11, 32'h400,  32'h404,  7, 1);
    cyc("drain_dual", 0, 2'b00, 32'h0,    32'h0,    0, 0, 0, 2'b11, 32'h408,  32'h40C,  5, 0);
    cyc("flush_stall",0, 2'b11, 32'h600,  32'h604,  1, 1, 0, 2'b00, 32'h0,    32'h0,    0, 0);
    // Walk rd_ptr (now 3) up to 7 for the wrap case.
    cyc("wrap_fill_a",0, 2'b11, 32'h700,  32'h704,  1, 0, 0, 2'b11, 32'h700,  32'h704,  2, 0);
    cyc("wrap_fill_b",0, 2'b11, 32'h708,  32'h70C,  1, 0, 0, 2'b11, 32'h700,  32'h704,  4, 0);
    cyc("wrap_deq",   0, 2'b00, 32'h0,    32'h0,    0, 0, 0, 2'b11, 32'h708,  32'h70C,  2, 0);
    cyc("wrap_enqdeq",0, 2'b11, 32'h200,  32'h204,  0, 0, 0, 2'b11, 32'h200,  32'h204,  2, 0);
    cyc("wrap_drain", 0, 2'b00, 32'h0,    32'h0,    0, 0, 0, 2'b00, 32'h0,    32'h0,    0, 0);
    cyc("slot1_only", 0, 2'b10, 32'hDEAD, 32'h306,  0, 0, 1, 2'b01, 32'h306,  32'h0,    1, 0);
    cyc("enq1_deq1",  0, 2'b01, 32'h310,  32'h0,    0, 0, 0, 2'b01, 32'h310,  32'h0,    1, 0);
    cyc("stall_enq",  0, 2'b01, 32'h314,  32'h0,    1, 0, 1, 2'b11, 32'h310,  32'h314,  2, 0);
    cyc("mid_reset",  1, 2'b11, 32'h900,  32'h904,  0, 0, 0, 2'b00, 32'h0,    32'h0,    0, 0);
    cyc("post_reset", 0, 2'b01, 32'h800,  32'h0,    1, 0, 0, 2'b01, 32'h800,  32'h0,    1, 0);
    cyc("post_single",0, 2'b00, 32'h0,    32'h0,    0, 0, 1, 2'b00, 32'h0,    32'h0,    0, 0);

    @(negedge clk);
    IF_Valid = 2'b00; Ctrl_StallID = 1'b0; Ctrl_FlushIFID = 1'b0;
    stim_done = 1'b1;
  end

  initial begin
    int guard;
    guard = 0;
    wait (stim_done);
    while (exp_q.size() != 0 && guard < 50) begin
      @(posedge clk);
      guard++;
    end
    #2;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain scoreboard_left=%0d required=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout stim_done=%0d required=1", stim_done);
    $fatal(1, "timeout");
  end

endmodule
